sp_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a request/ready front end, registered read data, a selectable read-during-write mode and a hardware clear sequencer. It generalises the fixed 128x8 single-port store to arbitrary width and depth. It sits between datapath FSMs and on-chip storage wherever a block needs a scratch memory with a known post-reset content.

---
 rtl/sp_ram_pkg.sv | 22 ++
 rtl/sp_ram_core.sv | 25 ++
 rtl/sp_ram_ctrl.sv | 142 ++++++++++++++
 tb/tb_sp_ram_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the sp_ram_ctrl slice.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    RDW_NO_CHANGE   = 2'd0,
    RDW_READ_FIRST  = 2'd1,
    RDW_WRITE_FIRST = 2'd2
  } rd_on_wr_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sp_ram_state_e;

  localparam int unsigned MAX_DATA_W = 64;

  // Callers zero-extend narrower words; the extra zeros do not affect parity.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Bare single-port storage array: synchronous write, asynchronous read.
import sp_ram_pkg::*;

module sp_ram_core #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller with clear sequencer and read-during-write modes.
// Optional parity storage/check enabled by defining SP_RAM_PARITY_EN.
import sp_ram_pkg::*;

module sp_ram_ctrl #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          ADDR_W    = 7,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0,
  parameter int unsigned          RD_ON_WR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              par_err
);

  localparam rd_on_wr_e MODE = rd_on_wr_e'(RD_ON_WR[1:0]);

`ifdef SP_RAM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  sp_ram_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic              accept;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] wr_data;
  logic [WORD_W-1:0] core_wdata;
  logic [WORD_W-1:0] core_rdata;

  logic              rvalid_d;
  logic [DATA_W-1:0] rdata_d;
  logic              par_err_d;
  logic              par_err_q;

  assign ready  = (state_q == ST_RUN);
  assign busy   = (state_q == ST_CLEAR);
  assign accept = req && ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr)             ptr_d   = '0;
        else if (ptr_q == '1) state_d = ST_RUN;
        else                 ptr_d   = ptr_q + ADDR_W'(1);
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage port: the sweep owns the array while busy, requests are ignored.
  always_comb begin
    core_we   = busy || (accept && we);
    core_addr = busy ? ptr_q : addr;
    wr_data   = busy ? CLEAR_VAL : wdata;
`ifdef SP_RAM_PARITY_EN
    core_wdata = {parity_of(wr_data), wr_data};
`else
    core_wdata = wr_data;
`endif
  end

  sp_ram_core #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

`ifdef SP_RAM_PARITY_EN
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    logic [MAX_DATA_W-1:0] ext;
    ext = '0;
    ext[DATA_W-1:0] = d;
    return even_parity(ext);
  endfunction
`endif

  // core_rdata is sampled before the write edge, so it is the old word.
  always_comb begin
    rvalid_d  = accept && (!we || (MODE != RDW_NO_CHANGE));
    rdata_d   = core_rdata[DATA_W-1:0];
    par_err_d = 1'b0;
    if (accept && we && (MODE == RDW_WRITE_FIRST)) begin
      rdata_d = wdata;
    end else begin
`ifdef SP_RAM_PARITY_EN
      par_err_d = parity_of(core_rdata[DATA_W-1:0]) != core_rdata[DATA_W];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rvalid    <= rvalid_d;
      par_err_q <= rvalid_d && par_err_d;
      if (rvalid_d) rdata <= rdata_d;
    end
  end

`ifdef SP_RAM_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed self-checking bench for sp_ram_ctrl (16x8, CLEAR_VAL 8'hA5), one instance per RD_ON_WR mode.
module tb_sp_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset, clr, req, we;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic       ready0, busy0, rvalid0, perr0;
  logic [7:0] rdata0;
  logic       ready1, busy1, rvalid1, perr1;
  logic [7:0] rdata1;
  logic       ready2, busy2, rvalid2, perr2;
  logic [7:0] rdata2;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  sp_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'hA5), .RD_ON_WR(0)) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready0), .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .par_err(perr0)
  );

  sp_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'hA5), .RD_ON_WR(1)) u_rf (
    .clk(clk), .reset(reset), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .par_err(perr1)
  );

  sp_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'hA5), .RD_ON_WR(2)) u_wf (
    .clk(clk), .reset(reset), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready2), .busy(busy2), .rvalid(rvalid2), .rdata(rdata2), .par_err(perr2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(input string tag);
    n = 0;
    while (!ready0 && n < 40) begin
      step();
      n++;
    end
    check(tag, n, 16);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    step(); step();
    check("rst_ready",  ready0,  1'b0);
    check("rst_busy",   busy0,   1'b1);
    check("rst_rvalid", rvalid0, 1'b0);
    check("rst_rdata",  rdata0,  8'h00);
    check("rst_parerr", perr0,   1'b0);

    reset = 1'b0;
    count_sweep("sweep_len_reset");
    check("run_busy", busy0, 1'b0);

    // read back the whole cleared array, one read per cycle
    req = 1'b1; we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      step();
      check($sformatf("clr_rv_%0d", i), rvalid0, 1'b1);
      check($sformatf("clr_rd_%0d", i), rdata0, 8'hA5);
    end
    req = 1'b0;
    step();
    check("idle_rvalid", rvalid0, 1'b0);
    check("idle_rdata_hold", rdata0, 8'hA5);

    // back-to-back: write 5, read 5, read 6
    req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h3C;
    step();
    check("b2b_wr_rv_m0", rvalid0, 1'b0);
    check("b2b_wr_rv_m1", rvalid1, 1'b1);
    check("b2b_wr_rd_m1", rdata1, 8'hA5);
    check("b2b_wr_rd_m2", rdata2, 8'h3C);
    we = 1'b0; addr = 4'd5;
    step();
    check("b2b_rd5_rv", rvalid0, 1'b1);
    check("b2b_rd5_rd", rdata0, 8'h3C);
    addr = 4'd6;
    step();
    check("b2b_rd6_rv", rvalid0, 1'b1);
    check("b2b_rd6_rd", rdata0, 8'hA5);
    req = 1'b0;
    step();
    check("b2b_end_rv", rvalid0, 1'b0);

    // read-during-write modes
    req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h11;
    step();
    wdata = 8'h22;
    step();
    check("rdw_m0_rv", rvalid0, 1'b0);
    check("rdw_m0_rd", rdata0, 8'hA5);
    check("rdw_m1_rv", rvalid1, 1'b1);
    check("rdw_m1_rd", rdata1, 8'h11);
    check("rdw_m2_rv", rvalid2, 1'b1);
    check("rdw_m2_rd", rdata2, 8'h22);
    check("rdw_m2_pe", perr2, 1'b0);
    we = 1'b0;
    step();
    check("rdw_rd2_m0", rdata0, 8'h22);
    check("rdw_rd2_m1", rdata1, 8'h22);

    // clr together with a read of addr 5; requests during the sweep are ignored
    addr = 4'd5; clr = 1'b1;
    step();
    check("clr_rd_rv", rvalid0, 1'b1);
    check("clr_rd_rd", rdata0, 8'h3C);
    check("clr_busy",  busy0,  1'b1);
    check("clr_ready", ready0, 1'b0);
    clr = 1'b0; we = 1'b1; addr = 4'd9; wdata = 8'hFF;
    count_sweep("sweep_len_clr");
    check("clr_ign_rv", rvalid0, 1'b0);
    we = 1'b0; addr = 4'd5;
    step();
    check("post_clr_rd5", rdata0, 8'hA5);
    addr = 4'd9;
    step();
    check("post_clr_rd9", rdata0, 8'hA5);

    // reset in mid-sweep
    we = 1'b1; addr = 4'd12; wdata = 8'h77;
    step();
    we = 1'b0;
    step();
    check("pre_rst_rd12", rdata0, 8'h77);
    req = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    check("mid_sweep_busy", busy0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy",  busy0,  1'b1);
    check("async_rst_ready", ready0, 1'b0);
    check("async_rst_rv",    rvalid0, 1'b0);
    check("async_rst_rd",    rdata0, 8'h00);
    step();
    reset = 1'b0;
    count_sweep("sweep_len_rst2");
    req = 1'b1; addr = 4'd12;
    step();
    check("post_rst_rd12", rdata0, 8'hA5);
    check("post_rst_pe", perr0, 1'b0);

`ifdef SP_RAM_PARITY_EN
    we = 1'b1; addr = 4'd3; wdata = 8'h0F;
    step();
    we = 1'b0;
    step();
    check("par_ok_rd", rdata0, 8'h0F);
    check("par_ok_pe", perr0, 1'b0);
    req = 1'b0;
    step();
    u_dut.u_core.mem[3] = u_dut.u_core.mem[3] ^ 9'h001;
    req = 1'b1;
    step();
    check("par_bad_rv", rvalid0, 1'b1);
    check("par_bad_rd", rdata0, 8'h0E);
    check("par_bad_pe", perr0, 1'b1);
`endif
    req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
